// File: rtl/z80_bus_responder.sv
// rtl/z80_bus_responder.sv - Z80 bus slave: small memory window plus one I/O port register, with optional wait states.
// Optional feature macro: RESPONDER_WAIT_STATES_EN (defined: insert WAIT_CYCLES wait states per hit access;
// undefined: no WAIT state, wait_n held at 1, WAIT_CYCLES ignored).
module z80_bus_responder #(
    parameter int          MEM_AW      = 4,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [7:0]  IO_PORT     = 8'h00,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        wait_n,
    output logic [7:0]  io_reg,
    output logic        io_wr_pulse,
    output logic [7:0]  access_count
);

    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef RESPONDER_WAIT_STATES_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t              state_q;
    logic [MEM_AW-1:0]   off_q;
    logic                is_io_q;
    logic                is_wr_q;
    logic [3:0]          wait_cnt_q;
    logic [7:0]          data_out_q;
    logic                data_oe_q;
    logic                wait_n_q;
    logic [7:0]          io_reg_q;
    logic                io_wr_pulse_q;
    logic [7:0]          count_q;
    logic [7:0]          mem_q [MEM_DEPTH];
    logic                prev_valid_q;
    logic                armed_q;

    logic                mem_set;
    logic                io_set;
    logic                valid;
    logic                all_high;
    logic                start;
    logic                hit;
    logic                held;
    logic                go_xfer;
    logic [MEM_AW-1:0]   off_d;
    logic                is_io_d;
    logic                is_wr_d;
    logic [7:0]          rd_data_d;

    // Strobe decode, edge/rearm qualified start, hit decode and next-access bookkeeping
    always_comb begin
        mem_set   = ~mreq_n & iorq_n & (rd_n ^ wr_n);
        io_set    = ~iorq_n & mreq_n & m1_n & (rd_n ^ wr_n);
        valid     = mem_set | io_set;
        all_high  = mreq_n & iorq_n & rd_n & wr_n;
        start     = (state_q == IDLE) & valid & ~prev_valid_q & armed_q;
        hit       = mem_set ? (addr[15:MEM_AW] == BASE_ADDR[15:MEM_AW])
                            : (addr[7:0] == IO_PORT);
        held      = (is_io_q ? ~iorq_n : ~mreq_n) & (is_wr_q ? ~wr_n : ~rd_n);
        off_d     = off_q;
        is_io_d   = is_io_q;
        is_wr_d   = is_wr_q;
        if (start) begin
            off_d   = addr[MEM_AW-1:0];
            is_io_d = io_set;
            is_wr_d = ~wr_n;
        end
        rd_data_d = is_io_d ? io_reg_q : mem_q[off_d];
        go_xfer   = 1'b0;
        if (state_q == IDLE && start && hit && !WAIT_EN) begin
            go_xfer = 1'b1;
        end
        if (state_q == WAIT && held && wait_cnt_q == 4'd0) begin
            go_xfer = 1'b1;
        end
    end

    // Access FSM with registered bus outputs, memory window and I/O register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            off_q         <= '0;
            is_io_q       <= 1'b0;
            is_wr_q       <= 1'b0;
            wait_cnt_q    <= 4'd0;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            wait_n_q      <= 1'b1;
            io_reg_q      <= 8'h00;
            io_wr_pulse_q <= 1'b0;
            count_q       <= 8'h00;
            prev_valid_q  <= 1'b0;
            armed_q       <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            prev_valid_q  <= valid;
            io_wr_pulse_q <= 1'b0;
            // A new access is only accepted once the bus has been fully idle
            if (all_high) begin
                armed_q <= 1'b1;
            end else if (start) begin
                armed_q <= 1'b0;
            end
            off_q   <= off_d;
            is_io_q <= is_io_d;
            is_wr_q <= is_wr_d;

            case (state_q)
                IDLE: begin
                    data_oe_q <= 1'b0;
                    wait_n_q  <= 1'b1;
                    if (start && hit && WAIT_EN) begin
                        state_q    <= WAIT;
                        wait_n_q   <= 1'b0;
                        wait_cnt_q <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (!held) begin
                        state_q  <= IDLE;
                        wait_n_q <= 1'b1;
                    end else if (wait_cnt_q == 4'd0) begin
                        wait_n_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                READ: begin
                    if (!held) begin
                        state_q   <= IDLE;
                        data_oe_q <= 1'b0;
                        count_q   <= count_q + 8'd1;
                    end
                end
                WRITE: begin
                    if (is_io_q) begin
                        io_reg_q <= data_in;
                    end else begin
                        mem_q[off_q] <= data_in;
                    end
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!held) begin
                        state_q <= IDLE;
                        count_q <= count_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Entry into the data phase, shared by the IDLE (no waits) and WAIT paths
            if (go_xfer) begin
                if (is_wr_d) begin
                    state_q       <= WRITE;
                    io_wr_pulse_q <= is_io_d;
                end else begin
                    state_q    <= READ;
                    data_oe_q  <= 1'b1;
                    data_out_q <= rd_data_d;
                end
            end
        end
    end

    assign data_out     = data_out_q;
    assign data_oe      = data_oe_q;
    assign wait_n       = WAIT_EN ? wait_n_q : 1'b1;
    assign io_reg       = io_reg_q;
    assign io_wr_pulse  = io_wr_pulse_q;
    assign access_count = count_q;

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 4: memory window address width (2**MEM_AW bytes).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000: window base; decode compares addr[15:MEM_AW] to BASE_ADDR[15:MEM_AW].
REQ-003 SHALL have parameter IO_PORT, default 8'h00: I/O port number, compared to addr[7:0].
REQ-004 SHALL have parameter WAIT_CYCLES, default 2 (range 1..15): wait states inserted per hit access.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports mreq_n, iorq_n, rd_n, wr_n, m1_n, input, 1 each: Z80 bus strobes, active-low, synchronous to clk.
REQ-008 SHALL have port addr, input, 16: Z80 address bus.
REQ-009 SHALL have port data_in, input, 8: write data from the CPU.
REQ-010 SHALL have port data_out, output, 8: read data to the CPU.
REQ-011 SHALL have port data_oe, output, 1: high while data_out is driven onto the bus.
REQ-012 SHALL have port wait_n, output, 1: active-low Z80 WAIT request.
REQ-013 SHALL have port io_reg, output, 8: current I/O port register value.
REQ-014 SHALL have port io_wr_pulse, output, 1: one-cycle pulse per I/O write.
REQ-015 SHALL have port access_count, output, 8: count of completed hit accesses.

Function
REQ-016 SHALL implement states IDLE, WAIT, READ, WRITE, HOLD.
REQ-017 IDLE SHALL detect access start when a valid strobe set is low in the current sample and was not low in the previous sample: memory = mreq_n&rd_n or mreq_n&wr_n low; I/O = iorq_n&rd_n or iorq_n&wr_n low with m1_n high.
REQ-018 The address SHALL be latched at detection; on a miss the FSM SHALL remain in IDLE with data_oe=0 and wait_n=1.
REQ-019 rd_n and wr_n both low, or mreq_n and iorq_n both low, SHALL be ignored (no hit); an interrupt acknowledge (m1_n and iorq_n low) SHALL be ignored.
REQ-020 On hit: IDLE->WAIT with wait_n=0 for exactly WAIT_CYCLES clocks, then READ or WRITE; wait_n SHALL return to 1 on entry to READ/WRITE.
REQ-021 READ SHALL drive data_out = mem[addr[MEM_AW-1:0]] (memory) or io_reg (I/O) with data_oe=1 until rd_n or the request strobe is high, then IDLE next cycle with data_oe=0.
REQ-022 WRITE SHALL capture data_in exactly once, on its first cycle, into mem or io_reg (I/O also asserts io_wr_pulse that cycle), then HOLD until wr_n or the request strobe is high, then IDLE.
REQ-023 Strobe deassertion during WAIT SHALL abort to IDLE next cycle: no write, no count, wait_n=1.
REQ-024 access_count SHALL increment by 1 on each READ/WRITE completion, wrapping 255->0; aborted and missed accesses SHALL NOT count.
REQ-025 A new access SHALL NOT be detected until all strobes have been seen high for at least one cycle after the previous access.

Reset
REQ-026 While rst=1: FSM=IDLE, data_out=8'h00, data_oe=0, wait_n=1, io_reg=8'h00, io_wr_pulse=0, access_count=0, all memory bytes cleared to 8'h00.
REQ-027 Reset asserted mid-access SHALL abort it with no write and no count; outputs take reset values on the next clock.

Configuration
REQ-028 Macro RESPONDER_WAIT_STATES_EN: when defined, waits per REQ-020; when undefined, WAIT state SHALL be skipped (IDLE->READ/WRITE directly), wait_n SHALL be constant 1, and WAIT_CYCLES is ignored.

Verification
REQ-029 Memory write addr=16'h0003, data_in=8'hA5 then memory read addr=16'h0003 -> wait_n low 2 cycles each, read data_out=8'hA5 with data_oe=1, access_count=2.
REQ-030 I/O write addr[7:0]=8'h00, data 8'h3C -> io_reg=8'h3C, io_wr_pulse high exactly 1 cycle; I/O read returns 8'h3C.
REQ-031 Memory read addr=16'h0010 (miss) -> data_oe=0, wait_n=1 throughout, access_count unchanged.
REQ-032 Memory write with mreq_n released after 1 wait cycle -> FSM IDLE, target byte unchanged, access_count unchanged.
REQ-033 256 completed reads -> access_count wraps to 8'h00; rst pulsed during WAIT -> wait_n=1, data_oe=0, memory cleared.
REQ-034 Build without RESPONDER_WAIT_STATES_EN: read of addr=16'h0000 -> wait_n never low, data_oe=1 one cycle after detection.
